// File: rtl/uart_rx_cfg_if.sv
// Serial-line and received-word signals of uart_rx_cfg, bundled with receiver/driver views.
// The slave view belongs to the receiver; the master view drives rx and s_tick.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
) ();
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;

    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  parity_err,
        input  frame_err,
        input  break_det
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output parity_err,
        output frame_err,
        output break_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with optional parity, frame-error and break detection.
// Define UART_RX_MAJORITY_EN to take every bit as a 2-of-3 vote over the last three s_ticks.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OS         = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_cfg_if.slave bus
);
    localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] SHalf = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] SBit  = SW'(OS - 1);
    localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast = NW'(DBIT - 1);
    localparam logic ParOn  = (PARITY_EN != 0);
    localparam logic ParOdd = (PARITY_ODD != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            parity_err_q;
    logic            frame_err_q;
    logic            break_q;
    logic            armed_q;
    logic            par_q;
    logic            stop_q;
    logic            rx_meta_q;
    logic            rxs_q;
    logic            smp;
    logic            par_exp;
    logic            stop_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Holds rxs from the two previous s_ticks so the vote lands on the nominal tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else if (bus.s_tick) begin
            hist_q <= {hist_q[0], rxs_q};
        end
    end

    always_comb begin
        smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
    end
`else
    always_comb begin
        smp = rxs_q;
    end
`endif

    always_comb begin
        par_exp  = (^b_q) ^ ParOdd;
        // With SB_TICK == OS the stop bit is sampled on the very tick that ends the frame.
        stop_now = (s_q == SBit) ? smp : stop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            armed_q      <= 1'b1;
            par_q        <= 1'b0;
            stop_q       <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!armed_q) begin
                        if (rxs_q) armed_q <= 1'b1;
                    end else if (!rxs_q) begin
                        state_q <= StStart;
                        s_q     <= '0;
                    end
                end
                StStart: begin
                    if (bus.s_tick) begin
                        if (s_q == SHalf) begin
                            s_q <= '0;
                            if (!smp) begin
                                state_q <= StData;
                                n_q     <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (bus.s_tick) begin
                        if (s_q == SBit) begin
                            s_q <= '0;
                            b_q <= {smp, b_q[DBIT-1:1]};
                            if (n_q == NLast) begin
                                state_q <= ParOn ? StParity : StStop;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (bus.s_tick) begin
                        if (s_q == SBit) begin
                            par_q   <= smp;
                            s_q     <= '0;
                            state_q <= StStop;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (bus.s_tick) begin
                        if (s_q == SBit) stop_q <= smp;
                        if (s_q == SStop) begin
                            state_q      <= StIdle;
                            s_q          <= '0;
                            done_q       <= 1'b1;
                            dout_q       <= b_q;
                            parity_err_q <= ParOn && (par_q != par_exp);
                            frame_err_q  <= !stop_now;
                            break_q      <= (b_q == '0) && !(ParOn && par_q) && !stop_now;
                            // A low stop bit disarms until the line goes idle again.
                            armed_q      <= stop_now;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = parity_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.break_det    = break_q;
endmodule
